// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - host-to-instruction-memory program loader; optional running XOR checksum under CHECKSUM_EN
module prog_loader #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_data,
    input  logic               in_last,
    output logic               memWrite,
    output logic [ADDR_W-1:0]  adr,
    output logic [INSTR_W-1:0] instruct,
    output logic               cpu_reset,
    output logic               load_done,
    output logic               err_ovf,
    output logic [ADDR_W:0]    word_cnt,
    output logic [INSTR_W-1:0] checksum
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WRITE   = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4
    } state_t;

    // Highest memory address; the word written there always ends the load.
    localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

    state_t state_q, state_d;

    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  adr_q, adr_d;
    logic [INSTR_W-1:0] instruct_q, instruct_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               load_done_q, load_done_d;
    logic               err_ovf_q, err_ovf_d;
    logic [ADDR_W:0]    word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic               last_q, last_d;
    logic               forced_q, forced_d;

    // A restart request in LOAD takes priority over a word offered the same cycle.
    logic xfer;
    assign xfer = (state_q == S_LOAD) && in_valid && !load_start;

    // Any accepted word is the last one if flagged by the host or if memory is full.
    logic ptr_full;
    assign ptr_full = (wr_ptr_q == PTR_MAX);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (load_start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (load_start)    state_d = S_LOAD;
                else if (in_valid) state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = last_q ? S_RELEASE : S_LOAD;
            end
            S_RELEASE: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (load_start) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: the host may only hand over a word while waiting in LOAD.
    always_comb begin
        in_ready = (state_q == S_LOAD) && !load_start;
    end

    // Datapath next-state: write port, counters, core reset and status flags.
    always_comb begin
        mem_write_d = mem_write_q;
        adr_d       = adr_q;
        instruct_d  = instruct_q;
        cpu_reset_d = cpu_reset_q;
        load_done_d = load_done_q;
        err_ovf_d   = err_ovf_q;
        word_cnt_d  = word_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        last_d      = last_q;
        forced_d    = forced_q;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (load_start) begin
                    wr_ptr_d    = '0;
                    word_cnt_d  = '0;
                    err_ovf_d   = 1'b0;
                    load_done_d = 1'b0;
                    cpu_reset_d = 1'b1;
                end
            end
            S_LOAD: begin
                if (load_start) begin
                    wr_ptr_d    = '0;
                    word_cnt_d  = '0;
                    err_ovf_d   = 1'b0;
                    load_done_d = 1'b0;
                    cpu_reset_d = 1'b1;
                end else if (xfer) begin
                    instruct_d  = in_data;
                    adr_d       = wr_ptr_q;
                    mem_write_d = 1'b1;
                    last_d      = in_last || ptr_full;
                    forced_d    = !in_last && ptr_full;
                end
            end
            S_WRITE: begin
                mem_write_d = 1'b0;
                word_cnt_d  = word_cnt_q + (ADDR_W+1)'(1);
                // The pointer is left alone after the final word so it never wraps.
                if (!last_q) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                if (last_q && forced_q) err_ovf_d = 1'b1;
            end
            S_RELEASE: begin
                cpu_reset_d = 1'b0;
                load_done_d = 1'b1;
            end
            default: begin
                mem_write_d = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset abandons any partial load and holds the core.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_write_q <= 1'b0;
            adr_q       <= '0;
            instruct_q  <= '0;
            cpu_reset_q <= 1'b1;
            load_done_q <= 1'b0;
            err_ovf_q   <= 1'b0;
            word_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            last_q      <= 1'b0;
            forced_q    <= 1'b0;
        end else begin
            mem_write_q <= mem_write_d;
            adr_q       <= adr_d;
            instruct_q  <= instruct_d;
            cpu_reset_q <= cpu_reset_d;
            load_done_q <= load_done_d;
            err_ovf_q   <= err_ovf_d;
            word_cnt_q  <= word_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            last_q      <= last_d;
            forced_q    <= forced_d;
        end
    end

`ifdef CHECKSUM_EN
    logic [INSTR_W-1:0] checksum_q, checksum_d;

    // Running XOR of every accepted word, restarted with each new load.
    always_comb begin
        checksum_d = checksum_q;
        if ((state_q == S_IDLE || state_q == S_LOAD || state_q == S_RUN) && load_start) begin
            checksum_d = '0;
        end else if (xfer) begin
            checksum_d = checksum_q ^ in_data;
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign memWrite  = mem_write_q;
    assign adr       = adr_q;
    assign instruct  = instruct_q;
    assign cpu_reset = cpu_reset_q;
    assign load_done = load_done_q;
    assign err_ovf   = err_ovf_q;
    assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard testbench for prog_loader
module tb_prog_loader;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_data;
    logic        in_last;
    logic        memWrite;
    logic [7:0]  adr;
    logic [9:0]  instruct;
    logic        cpu_reset;
    logic        load_done;
    logic        err_ovf;
    logic [8:0]  word_cnt;
    logic [9:0]  checksum;

    prog_loader #(.ADDR_W(8), .INSTR_W(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .memWrite   (memWrite),
        .adr        (adr),
        .instruct   (instruct),
        .cpu_reset  (cpu_reset),
        .load_done  (load_done),
        .err_ovf    (err_ovf),
        .word_cnt   (word_cnt),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [17:0] exp_q[$];
    logic [7:0]  exp_ptr;
    logic [9:0]  chk_model;
    logic        prev_mw;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_chk();
`ifdef CHECKSUM_EN
        return 32'(chk_model);
`else
        return 32'd0;
`endif
    endfunction

    // Write-port monitor: every strobe must match the oldest queued word.
    always @(negedge clk) begin
        if (reset && memWrite) begin
            check_eq("mw_single", 32'(prev_mw), 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("spurious_write", 32'(memWrite), 32'd0);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check_eq("wr_adr", 32'(adr), 32'(e[17:10]));
                check_eq("wr_data", 32'(instruct), 32'(e[9:0]));
            end
        end
        prev_mw = reset && memWrite;
    end

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        exp_ptr   = 8'd0;
        chk_model = 10'd0;
    endtask

    task automatic send_word(input logic [9:0] d, input logic l, output int waits);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waits    = 0;
        @(negedge clk);
        while (!in_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check_eq("send_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            exp_q.push_back({exp_ptr, d});
            exp_ptr   = exp_ptr + 8'd1;
            chk_model = chk_model ^ d;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [9:0] words3 [3];
    int w;

    initial begin
        reset      = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        exp_ptr    = '0;
        chk_model  = '0;
        prev_mw    = 1'b0;
        words3[0] = 10'h3A1;
        words3[1] = 10'h055;
        words3[2] = 10'h2FF;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        check_eq("rst_memWrite", 32'(memWrite), 32'd0);
        check_eq("rst_adr", 32'(adr), 32'd0);
        check_eq("rst_instruct", 32'(instruct), 32'd0);
        check_eq("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("rst_load_done", 32'(load_done), 32'd0);
        check_eq("rst_err_ovf", 32'(err_ovf), 32'd0);
        check_eq("rst_word_cnt", 32'(word_cnt), 32'd0);
        check_eq("rst_checksum", 32'(checksum), 32'd0);

        // in_valid while IDLE must be ignored
        in_valid = 1'b1;
        in_data  = 10'h123;
        repeat (3) begin
            @(negedge clk);
            check_eq("idle_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        // Three-word program with continuous valid
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            send_word(words3[i], i == 2, w);
            if (i > 0) check_eq("cont_gap", 32'(w), 32'd1);
        end
        in_valid = 1'b0;
        check_eq("p3_cpu_reset_w", 32'(cpu_reset), 32'd1);
        step();
        check_eq("p3_cpu_reset_rel", 32'(cpu_reset), 32'd1);
        check_eq("p3_load_done_rel", 32'(load_done), 32'd0);
        step();
        check_eq("p3_cpu_reset_run", 32'(cpu_reset), 32'd0);
        check_eq("p3_load_done", 32'(load_done), 32'd1);
        check_eq("p3_word_cnt", 32'(word_cnt), 32'd3);
        check_eq("p3_err_ovf", 32'(err_ovf), 32'd0);
        check_eq("p3_checksum", 32'(checksum), exp_chk());

        // Restart from RUN with a single-word program
        pulse_start();
        check_eq("sw_cpu_reset_start", 32'(cpu_reset), 32'd1);
        check_eq("sw_load_done_start", 32'(load_done), 32'd0);
        check_eq("sw_word_cnt_start", 32'(word_cnt), 32'd0);
        send_word(10'h0AB, 1'b1, w);
        in_valid = 1'b0;
        step();
        check_eq("sw_load_done_rel", 32'(load_done), 32'd0);
        step();
        check_eq("sw_load_done", 32'(load_done), 32'd1);
        check_eq("sw_word_cnt", 32'(word_cnt), 32'd1);

        // Fill memory without in_last
        pulse_start();
        for (int i = 0; i < 256; i++) begin
            send_word(10'($urandom_range(0, 1023)), 1'b0, w);
        end
        in_valid = 1'b0;
        step();
        step();
        check_eq("ovf_err", 32'(err_ovf), 32'd1);
        check_eq("ovf_word_cnt", 32'(word_cnt), 32'd256);
        check_eq("ovf_load_done", 32'(load_done), 32'd1);
        check_eq("ovf_cpu_reset", 32'(cpu_reset), 32'd0);
        check_eq("ovf_checksum", 32'(checksum), exp_chk());
        in_valid = 1'b1;
        in_data  = 10'h1FF;
        repeat (4) begin
            @(negedge clk);
            check_eq("ovf_no_257", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;

        // Reload from RUN clears the overflow flag
        pulse_start();
        check_eq("rl_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("rl_err_clr", 32'(err_ovf), 32'd0);
        send_word(10'h001, 1'b1, w);
        in_valid = 1'b0;
        step();
        step();
        check_eq("rl_word_cnt", 32'(word_cnt), 32'd1);
        check_eq("rl_err_ovf", 32'(err_ovf), 32'd0);
        check_eq("rl_load_done", 32'(load_done), 32'd1);
        check_eq("rl_checksum", 32'(checksum), exp_chk());

        // load_start in LOAD restarts and refuses a simultaneous word
        pulse_start();
        send_word(10'h155, 1'b0, w);
        in_valid = 1'b0;
        step();
        @(negedge clk);
        load_start = 1'b1;
        in_valid   = 1'b1;
        in_data    = 10'h3FF;
        in_last    = 1'b1;
        #1;
        check_eq("rs_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        exp_ptr    = 8'd0;
        chk_model  = 10'd0;
        check_eq("rs_memWrite", 32'(memWrite), 32'd0);
        check_eq("rs_word_cnt", 32'(word_cnt), 32'd0);
        send_word(10'h2AA, 1'b1, w);
        in_valid = 1'b0;
        step();
        step();
        check_eq("rs_word_cnt_end", 32'(word_cnt), 32'd1);
        check_eq("rs_checksum", 32'(checksum), exp_chk());

        // Asynchronous reset during the second word's write cycle
        pulse_start();
        send_word(10'h011, 1'b0, w);
        send_word(10'h022, 1'b0, w);
        in_valid = 1'b0;
        check_eq("ar_mw_before", 32'(memWrite), 32'd1);
        #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check_eq("ar_memWrite", 32'(memWrite), 32'd0);
        check_eq("ar_adr", 32'(adr), 32'd0);
        check_eq("ar_cpu_reset", 32'(cpu_reset), 32'd1);
        check_eq("ar_word_cnt", 32'(word_cnt), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("ar_idle_ready", 32'(in_ready), 32'd0);
        pulse_start();
        send_word(10'h2C3, 1'b1, w);
        in_valid = 1'b0;
        step();
        step();
        check_eq("ar_word_cnt_end", 32'(word_cnt), 32'd1);
        check_eq("ar_load_done", 32'(load_done), 32'd1);

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
